// File: rtl/sram_bist_ctrl_if.sv
// rtl/sram_bist_ctrl_if.sv - SRAM pin bundle between the BIST sequencer and the board-level SRAM
interface sram_bist_ctrl_if #(
  parameter int pADDR_WIDTH = 20
);
  logic [pADDR_WIDTH-1:0] SRAM_A;
  logic [7:0]             dq_out;
  logic                   dq_oe;
  logic [7:0]             dq_in;
  logic                   SRAM_CEn;
  logic                   SRAM_CE2;
  logic                   SRAM_OEn;
  logic                   SRAM_WEn;

  // Sequencer side drives the pins, memory side returns read data
  modport master (
    output SRAM_A, dq_out, dq_oe, SRAM_CEn, SRAM_CE2, SRAM_OEn, SRAM_WEn,
    input  dq_in
  );

  modport slave (
    input  SRAM_A, dq_out, dq_oe, SRAM_CEn, SRAM_CE2, SRAM_OEn, SRAM_WEn,
    output dq_in
  );
endinterface

// File: rtl/sram_bist_ctrl.sv
// rtl/sram_bist_ctrl.sv - write/read-back self-test sequencer for the external async SRAM
module sram_bist_ctrl #(
  parameter int pADDR_WIDTH = 20,
  parameter int pWR_CYCLES  = 2,
  parameter int pRD_CYCLES  = 2
) (
  input  logic                   usb_clk,
  input  logic                   reset,
  input  logic                   en,
  input  logic [pADDR_WIDTH-1:0] mem_bytes,
  input  logic [7:0]             seed,
  sram_bist_ctrl_if.master       sram,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [15:0]            error_count,
  output logic [pADDR_WIDTH-1:0] first_fail_addr
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_SETUP,
    S_WR_PULSE,
    S_WR_HOLD,
    S_RD_SETUP,
    S_RD_WAIT,
    S_DONE
  } state_t;

  localparam logic [3:0] WR_LAST = 4'(pWR_CYCLES - 1);
  localparam logic [3:0] RD_LAST = 4'(pRD_CYCLES - 1);

  state_t                 state_q, state_d;
  logic                   en_q;
  logic [pADDR_WIDTH-1:0] addr_q, addr_d;
  logic [pADDR_WIDTH-1:0] len_q, len_d;
  logic [7:0]             seed_q, seed_d;
  logic [3:0]             cnt_q, cnt_d;
  logic                   done_d, pass_d, busy_d;
  logic [15:0]            err_d;
  logic [pADDR_WIDTH-1:0] ffa_d;
  logic                   start;
  logic                   last_addr;
  logic                   running;

  logic [pADDR_WIDTH-1:0] a_d;
  logic [7:0]             dq_out_d;
  logic                   dq_oe_d, cen_d, ce2_d, oen_d, wen_d;

  function automatic logic [7:0] pattern(input logic [pADDR_WIDTH-1:0] a, input logic [7:0] s);
    return a[7:0] ^ s;
  endfunction

  assign start     = en & ~en_q;
  assign last_addr = (addr_q == len_q - pADDR_WIDTH'(1));
  assign running   = (state_q != S_IDLE) && (state_q != S_DONE);

  // Sequencer state, address walk, pulse counter and result registers
  always_ff @(posedge usb_clk or posedge reset) begin
    if (reset) begin
      state_q         <= S_IDLE;
      en_q            <= 1'b0;
      addr_q          <= '0;
      len_q           <= '0;
      seed_q          <= '0;
      cnt_q           <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      error_count     <= '0;
      first_fail_addr <= '0;
    end else begin
      state_q         <= state_d;
      en_q            <= en;
      addr_q          <= addr_d;
      len_q           <= len_d;
      seed_q          <= seed_d;
      cnt_q           <= cnt_d;
      busy            <= busy_d;
      done            <= done_d;
      pass            <= pass_d;
      error_count     <= err_d;
      first_fail_addr <= ffa_d;
    end
  end

  // Next-state logic plus pin values decoded from the upcoming state so the pins are registered
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    len_d    = len_q;
    seed_d   = seed_q;
    cnt_d    = cnt_q;
    done_d   = done;
    pass_d   = pass;
    err_d    = error_count;
    ffa_d    = first_fail_addr;

    if (running && !en) begin
      // Abort keeps partial error results but never reports completion
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            done_d  = 1'b0;
            pass_d  = 1'b0;
            err_d   = '0;
            ffa_d   = '0;
            len_d   = mem_bytes;
            seed_d  = seed;
            addr_d  = '0;
            cnt_d   = '0;
            state_d = (mem_bytes == '0) ? S_DONE : S_WR_SETUP;
          end
        end
        S_WR_SETUP: begin
          cnt_d   = '0;
          state_d = S_WR_PULSE;
        end
        S_WR_PULSE: begin
          if (cnt_q == WR_LAST) state_d = S_WR_HOLD;
          else                  cnt_d   = cnt_q + 4'd1;
        end
        S_WR_HOLD: begin
          // Compare before incrementing so the address never wraps
          if (last_addr) begin
            addr_d  = '0;
            state_d = S_RD_SETUP;
          end else begin
            addr_d  = addr_q + pADDR_WIDTH'(1);
            state_d = S_WR_SETUP;
          end
        end
        S_RD_SETUP: begin
          cnt_d   = '0;
          state_d = S_RD_WAIT;
        end
        S_RD_WAIT: begin
          if (cnt_q == RD_LAST) begin
            if (sram.dq_in != pattern(addr_q, seed_q)) begin
              if (error_count != 16'hFFFF) err_d = error_count + 16'd1;
              if (error_count == 16'd0)    ffa_d = addr_q;
            end
            if (last_addr) begin
              state_d = S_DONE;
            end else begin
              addr_d  = addr_q + pADDR_WIDTH'(1);
              state_d = S_RD_SETUP;
            end
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        S_DONE: begin
          done_d  = 1'b1;
          pass_d  = (error_count == 16'd0);
          state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end

    busy_d   = (state_d != S_IDLE) && (state_d != S_DONE);

    a_d      = '0;
    dq_out_d = '0;
    dq_oe_d  = 1'b0;
    cen_d    = 1'b1;
    ce2_d    = 1'b0;
    oen_d    = 1'b1;
    wen_d    = 1'b1;
    case (state_d)
      S_WR_SETUP, S_WR_PULSE, S_WR_HOLD: begin
        cen_d    = 1'b0;
        ce2_d    = 1'b1;
        a_d      = addr_d;
        dq_out_d = pattern(addr_d, seed_d);
        dq_oe_d  = 1'b1;
        wen_d    = (state_d != S_WR_PULSE);
      end
      S_RD_SETUP, S_RD_WAIT: begin
        cen_d = 1'b0;
        ce2_d = 1'b1;
        a_d   = addr_d;
        oen_d = 1'b0;
      end
      default: begin
        cen_d = 1'b1;
      end
    endcase
  end

  // Registered SRAM pin drivers
  always_ff @(posedge usb_clk or posedge reset) begin
    if (reset) begin
      sram.SRAM_A   <= '0;
      sram.dq_out   <= '0;
      sram.dq_oe    <= 1'b0;
      sram.SRAM_CEn <= 1'b1;
      sram.SRAM_CE2 <= 1'b0;
      sram.SRAM_OEn <= 1'b1;
      sram.SRAM_WEn <= 1'b1;
    end else begin
      sram.SRAM_A   <= a_d;
      sram.dq_out   <= dq_out_d;
      sram.dq_oe    <= dq_oe_d;
      sram.SRAM_CEn <= cen_d;
      sram.SRAM_CE2 <= ce2_d;
      sram.SRAM_OEn <= oen_d;
      sram.SRAM_WEn <= wen_d;
    end
  end

endmodule

// File: tb/tb_sram_bist_ctrl.sv
// tb/tb_sram_bist_ctrl.sv - self-checking bench for sram_bist_ctrl with an SRAM model and fault injection
module tb_sram_bist_ctrl;
  localparam int AW  = 12;
  localparam int WRC = 2;
  localparam int RDC = 2;
  localparam int DEPTH = 1 << AW;

  logic          usb_clk = 1'b0;
  logic          reset;
  logic          en;
  logic [AW-1:0] mem_bytes;
  logic [7:0]    seed;
  logic          busy, done, pass;
  logic [15:0]   error_count;
  logic [AW-1:0] first_fail_addr;

  sram_bist_ctrl_if #(.pADDR_WIDTH(AW)) sif ();

  sram_bist_ctrl #(.pADDR_WIDTH(AW), .pWR_CYCLES(WRC), .pRD_CYCLES(RDC)) dut (
    .usb_clk(usb_clk), .reset(reset), .en(en), .mem_bytes(mem_bytes), .seed(seed),
    .sram(sif.master), .busy(busy), .done(done), .pass(pass),
    .error_count(error_count), .first_fail_addr(first_fail_addr)
  );

  always #5 usb_clk = ~usb_clk;

  logic [7:0] mem       [0:DEPTH-1];
  logic [7:0] fault_xor [0:DEPTH-1];
  logic [7:0] and_mask;

  always @(posedge usb_clk) begin
    if (!sif.SRAM_CEn && !sif.SRAM_WEn) mem[sif.SRAM_A] <= sif.dq_out;
  end

  assign sif.dq_in = (!sif.SRAM_CEn && !sif.SRAM_OEn) ?
                     ((mem[sif.SRAM_A] ^ fault_xor[sif.SRAM_A]) & and_mask) : 8'h00;

  int checks = 0;
  int errors = 0;
  int busy_cnt = 0;
  bit busy_seen, we_low_seen, oe_low_seen;
  logic [AW-1:0] prev_a = '0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge usb_clk) begin
    if (!reset) begin
      check("no_contention", longint'(sif.dq_oe && !sif.SRAM_OEn), 0);
      if (!sif.SRAM_WEn) begin
        check("we_needs_oe", longint'(sif.dq_oe), 1);
        check("we_addr_stable", longint'(sif.SRAM_A), longint'(prev_a));
        we_low_seen = 1'b1;
      end
      if (!sif.SRAM_OEn) oe_low_seen = 1'b1;
      if (busy) begin
        busy_cnt++;
        busy_seen = 1'b1;
      end
    end
    prev_a = sif.SRAM_A;
  end

  task automatic clear_faults();
    for (int a = 0; a < DEPTH; a++) fault_xor[a] = 8'h00;
    and_mask = 8'hFF;
  endtask

  // Reference: every location should read back its pattern; any difference after the fault path counts
  task automatic model(input int n, input logic [7:0] s, output int exp_err, output int exp_ffa);
    logic [7:0] want, got;
    exp_err = 0;
    exp_ffa = 0;
    for (int a = 0; a < n; a++) begin
      want = 8'(a & 255) ^ s;
      got  = (want ^ fault_xor[a]) & and_mask;
      if (got != want) begin
        if (exp_err == 0) exp_ffa = a;
        if (exp_err < 65535) exp_err++;
      end
    end
  endtask

  task automatic run_test(input string name, input int n, input logic [7:0] s,
                          input int exp_err, input int exp_ffa, input bit exp_pass, input bit scramble);
    int bad;
    en = 1'b0;
    @(posedge usb_clk); #1;
    mem_bytes = AW'(n);
    seed      = s;
    busy_cnt  = 0;
    en        = 1'b1;
    @(posedge usb_clk); #1;
    check({name, "_start_clear"}, longint'({done, pass, error_count, first_fail_addr}), 0);
    if (scramble) begin
      mem_bytes = AW'($urandom);
      seed      = 8'($urandom);
    end
    for (int i = 0; i < 20000 && !done; i++) begin
      @(posedge usb_clk); #1;
    end
    @(posedge usb_clk); #1;
    check({name, "_done"}, longint'(done), 1);
    check({name, "_pass"}, longint'(pass), longint'(exp_pass));
    check({name, "_errcnt"}, longint'(error_count), exp_err);
    check({name, "_ffa"}, longint'(first_fail_addr), exp_ffa);
    check({name, "_busy_cycles"}, busy_cnt, (WRC + 2) * n + (RDC + 1) * n);
    bad = 0;
    for (int a = 0; a < n; a++) if (mem[a] !== (8'(a & 255) ^ s)) bad++;
    check({name, "_mem_image"}, bad, 0);
  endtask

  typedef struct {
    int         n;
    logic [7:0] s;
    logic [7:0] mask;
    int         faddr;
    logic [7:0] fval;
    int         exp_err;
    int         exp_ffa;
    bit         exp_pass;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int e_err, e_ffa, n, k;
    logic [7:0] s;

    vecs[0] = '{4,   8'hA5, 8'hFF, -1,  8'h00, 0,   0,   1'b1};
    vecs[1] = '{4,   8'hA5, 8'hFE, -1,  8'h00, 2,   0,   1'b0};
    vecs[2] = '{0,   8'h5A, 8'hFF, -1,  8'h00, 0,   0,   1'b1};
    vecs[3] = '{16,  8'h3C, 8'hFF, 9,   8'h01, 1,   9,   1'b0};
    vecs[4] = '{3,   8'h00, 8'h7F, -1,  8'h00, 0,   0,   1'b1};
    vecs[5] = '{256, 8'h80, 8'h7F, -1,  8'h00, 128, 0,   1'b0};
    vecs[6] = '{300, 8'h00, 8'hFF, 299, 8'h10, 1,   299, 1'b0};

    reset = 1'b1;
    en = 1'b0;
    mem_bytes = '0;
    seed = '0;
    clear_faults();
    repeat (3) @(posedge usb_clk);
    #1;
    check("rst_pins", longint'({sif.SRAM_A, sif.dq_out, sif.dq_oe, sif.SRAM_CEn, sif.SRAM_CE2,
                                sif.SRAM_OEn, sif.SRAM_WEn}), longint'({12'd0, 8'd0, 5'b01011}));
    check("rst_status", longint'({busy, done, pass, error_count, first_fail_addr}), 0);
    reset = 1'b0;

    for (int i = 0; i < 7; i++) begin
      clear_faults();
      and_mask = vecs[i].mask;
      if (vecs[i].faddr >= 0) fault_xor[vecs[i].faddr] = vecs[i].fval;
      run_test($sformatf("vec%0d", i), vecs[i].n, vecs[i].s,
               vecs[i].exp_err, vecs[i].exp_ffa, vecs[i].exp_pass, 1'b0);
    end

    busy_seen = 1'b0;
    repeat (40) @(posedge usb_clk);
    #1;
    check("hold_no_rerun", longint'(busy_seen), 0);
    check("hold_done_sticky", longint'(done), 1);
    clear_faults();
    run_test("rerun", 4, 8'hA5, 0, 0, 1'b1, 1'b0);

    en = 1'b0;
    @(posedge usb_clk); #1;
    mem_bytes = '0;
    we_low_seen = 1'b0;
    oe_low_seen = 1'b0;
    en = 1'b1;
    @(posedge usb_clk); #1;
    check("zero_done_cleared", longint'(done), 0);
    @(posedge usb_clk); #1;
    check("zero_done_pass", longint'({done, pass}), 3);
    repeat (3) @(posedge usb_clk);
    #1;
    check("zero_no_strobes", longint'({we_low_seen, oe_low_seen}), 0);

    en = 1'b0;
    @(posedge usb_clk); #1;
    mem_bytes = AW'(8);
    en = 1'b1;
    repeat (5) @(posedge usb_clk);
    #1;
    en = 1'b0;
    @(posedge usb_clk); #1;
    check("abort_release", longint'({busy, sif.SRAM_WEn, sif.SRAM_CEn, sif.dq_oe, sif.SRAM_OEn}),
          longint'(5'b01101));
    repeat (5) @(posedge usb_clk);
    #1;
    check("abort_no_done", longint'(done), 0);
    run_test("after_abort", 8, 8'h11, 0, 0, 1'b1, 1'b0);

    for (int r = 0; r < 8; r++) begin
      clear_faults();
      n = $urandom_range(1, 200);
      s = 8'($urandom);
      k = $urandom_range(0, 3);
      for (int j = 0; j < k; j++) fault_xor[$urandom_range(0, n - 1)] = 8'($urandom_range(1, 255));
      if ($urandom_range(0, 3) == 0) and_mask = 8'($urandom);
      model(n, s, e_err, e_ffa);
      run_test($sformatf("rand%0d", r), n, s, e_err, e_ffa, e_err == 0, 1'b1);
    end

    clear_faults();
    en = 1'b0;
    @(posedge usb_clk); #1;
    mem_bytes = AW'(20);
    en = 1'b1;
    repeat (10) @(posedge usb_clk);
    #2;
    reset = 1'b1;
    #1;
    check("arst_pins", longint'({sif.SRAM_A, sif.dq_out, sif.dq_oe, sif.SRAM_CEn, sif.SRAM_CE2,
                                 sif.SRAM_OEn, sif.SRAM_WEn}), longint'({12'd0, 8'd0, 5'b01011}));
    check("arst_status", longint'({busy, done, pass, error_count, first_fail_addr}), 0);
    @(posedge usb_clk); #1;
    reset = 1'b0;
    run_test("after_reset", 5, 8'hC3, 0, 0, 1'b1, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sram_bist_ctrl.md
Name: sram_bist_ctrl

Overview:
- Built-in self-test sequencer for the external async SRAM on the CW310.
- Sits between the USB register block, which supplies `REG_SRAM_EN` / `REG_SRAM_MEM_BYTES` and reads back status, and the top-level SRAM pins.
- On a start edge it writes a seeded pattern to addresses 0..mem_bytes-1, reads every location back, compares each byte and reports pass/fail, error count and first failing address.
- The SRAM_DQ tristate buffer is instantiated in the top level, not in this block.

Parameters:
- pADDR_WIDTH, 20, SRAM address width.
- pWR_CYCLES, 2, usb_clk cycles SRAM_WEn is held low per write (1..15).
- pRD_CYCLES, 2, usb_clk cycles from address/OEn valid to data sample (1..15).

Ports:
- usb_clk  in  1  block clock.
- reset  in  1  asynchronous, active-high reset.
- en  in  1  run enable from REG_SRAM_EN[0]; a rising edge starts a test, a low level aborts it.
- mem_bytes  in  pADDR_WIDTH  number of bytes to test; 0 means complete immediately with pass.
- seed  in  8  pattern seed.
- SRAM_A  out  pADDR_WIDTH  SRAM address.
- dq_out  out  8  write data to top-level tristate.
- dq_oe  out  1  drive enable for SRAM_DQ.
- dq_in  in  8  SRAM_DQ as seen at the pin.
- SRAM_CEn  out  1  active-low chip enable.
- SRAM_CE2  out  1  active-high chip enable.
- SRAM_OEn  out  1  active-low output enable.
- SRAM_WEn  out  1  active-low write enable.
- busy  out  1  test in progress.
- done  out  1  sticky completion flag.
- pass  out  1  valid when done=1: 1 = no mismatches.
- error_count  out  16  mismatch count, saturating at 0xFFFF.
- first_fail_addr  out  pADDR_WIDTH  address of the first mismatch; 0 if none.

Behaviour:
- Reset values:
  - SRAM_A=0, dq_out=0, dq_oe=0.
  - SRAM_CEn=1, SRAM_CE2=0, SRAM_OEn=1, SRAM_WEn=1.
  - busy=0, done=0, pass=0, error_count=0, first_fail_addr=0.
  - FSM in IDLE.
- Start detection: en is registered once. start = en & ~en_q. Holding en high does not retrigger.
- Pattern: data(a) = a[7:0] XOR seed.
- On start, in the same cycle:
  - clear done, pass, error_count, first_fail_addr.
  - latch mem_bytes and seed; addr=0.
  - if latched mem_bytes==0, go to DONE; otherwise go to WR_SETUP.
- FSM states:
  - IDLE: all SRAM controls inactive.
  - WR_SETUP (1 cycle):
    - CEn=0, CE2=1, SRAM_A=addr.
    - dq_out=data(addr), dq_oe=1, WEn=1.
  - WR_PULSE (pWR_CYCLES cycles): WEn=0; address and data held.
  - WR_HOLD (1 cycle):
    - WEn=1; dq_oe stays 1 and address/data are held, giving hold time.
    - If addr==mem_bytes-1: addr=0, go to RD_SETUP. Otherwise addr+1, go to WR_SETUP.
  - RD_SETUP (1 cycle): SRAM_A=addr, dq_oe=0, OEn=0.
  - RD_WAIT (pRD_CYCLES cycles):
    - Compare dq_in against data(addr) on the last cycle.
    - On mismatch: error_count+1 (saturating). If it was 0 before, first_fail_addr=addr.
    - Then, if addr==mem_bytes-1, go to DONE; otherwise addr+1, go to RD_SETUP.
  - DONE (1 cycle):
    - release all SRAM controls.
    - done=1, pass=(error_count==0).
    - go to IDLE.
- busy: 1 in every state except IDLE and DONE.
- Latency: one full test occupies (pWR_CYCLES+2)*N + (pRD_CYCLES+1)*N cycles in busy.
- Output decoding: all SRAM outputs are registered. dq_oe and SRAM_OEn are never both active; there is no bus contention.
- Abort: en low while busy forces IDLE next cycle.
  - releases SRAM (WEn=1, OEn=1, CEn=1, dq_oe=0).
  - done stays 0; error_count and first_fail_addr keep partial values.
- Address wrap: mem_bytes is compared before incrementing, so addr never wraps. mem_bytes=2^pADDR_WIDTH-1 is the largest test.
- Timing changes mid-run: changes to mem_bytes or seed while busy have no effect.
- Async reset mid-operation: returns all outputs to reset values immediately.

Test Plan:
- mem_bytes=4, seed=0xA5, ideal SRAM model:
  - writes 0xA5,0xA4,0xA7,0xA6 to addresses 0..3.
  - busy high exactly 28 cycles; then done=1, pass=1, error_count=0.
- Same setup, bit 0 of dq_in forced to 0 on reads:
  - error_count=2, first_fail_addr=0, pass=0.
- mem_bytes=0, en 0->1:
  - done=1, pass=1 two cycles after the edge.
  - SRAM_WEn and SRAM_OEn never go low.
- mem_bytes=8, en dropped 5 cycles after start:
  - within 1 cycle, busy=0, SRAM_WEn=1, SRAM_CEn=1, dq_oe=0.
  - done stays 0.
  - A new rising edge then runs a full test to pass=1.
- en held high after completion:
  - no second run.
  - toggle en 1->0->1 and the test reruns with cleared counters.
- Assertions across all tests:
  - no cycle with dq_oe=1 and SRAM_OEn=0.
  - SRAM_WEn is low only while dq_oe=1 and the address is stable.
